// File: rtl/nes_button_events.sv
// nes_button_events: polls an NES controller reader and turns snapshot changes into a press/release event FIFO
module nes_button_events #(
  parameter int CYCLES_PER_POLL = 416667,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic       clk,
  input  logic       i_rst,
  output logic       o_read_buttons,
  input  logic       i_valid,
  input  logic [7:0] i_buttons,
  output logic [7:0] o_state,
  output logic       o_event_valid,
  input  logic       i_event_ready,
  output logic [2:0] o_event_button,
  output logic       o_event_pressed,
  output logic       o_overflow,
  output logic       o_timeout
);
  localparam int PW = $clog2(CYCLES_PER_POLL);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, REQUEST, COLLECT, DIFF} state_t;
  state_t fsm_q, fsm_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0] snap_q, snap_d, mask_q, mask_d, btn_q, btn_d;
  logic [2:0] idx_q, idx_d, cnt_q;
  logic [1:0] rd_q, wr_q;
  logic [3:0] mem_q [4];
  logic pend_q, pend_d, tout_q, tout_d, ovf_q, wrap, push, pop, acc;
  logic [3:0] push_data;
  assign wrap = poll_q == PW'(CYCLES_PER_POLL - 1);
  assign poll_d = wrap ? '0 : poll_q + PW'(1);
  assign push_data = {idx_q, snap_q[idx_q]};
  always_comb begin
    fsm_d = fsm_q;
    pend_d = pend_q | wrap;
    tcnt_d = tcnt_q;
    snap_d = snap_q;
    mask_d = mask_q;
    idx_d = idx_q;
    btn_d = btn_q;
    tout_d = 1'b0;
    push = 1'b0;
    case (fsm_q)
      IDLE: if (pend_q) begin
        pend_d = wrap;
        fsm_d = REQUEST;
      end
      REQUEST: begin
        tcnt_d = '0;
        fsm_d = COLLECT;
      end
      COLLECT: if (i_valid) begin
        snap_d = i_buttons;
        mask_d = i_buttons ^ btn_q;
        idx_d = 3'd7;
        fsm_d = DIFF;
      end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tout_d = 1'b1;
        fsm_d = IDLE;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
      DIFF: begin
        push = mask_q[idx_q];
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          btn_d = snap_q;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end
  // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign pop = o_event_valid & i_event_ready;
  assign acc = push & (~cnt_q[2] | pop);
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      fsm_q <= IDLE;
      poll_q <= '0;
      pend_q <= 1'b0;
      tcnt_q <= '0;
      snap_q <= '0;
      mask_q <= '0;
      idx_q <= '0;
      btn_q <= '0;
      tout_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      poll_q <= poll_d;
      pend_q <= pend_d;
      tcnt_q <= tcnt_d;
      snap_q <= snap_d;
      mask_q <= mask_d;
      idx_q <= idx_d;
      btn_q <= btn_d;
      tout_q <= tout_d;
      rd_q <= rd_q + {1'b0, pop};
      wr_q <= wr_q + {1'b0, acc};
      cnt_q <= cnt_q + {2'b0, acc} - {2'b0, pop};
      ovf_q <= ovf_q | (push & cnt_q[2] & ~pop);
    end
  end
  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q] <= push_data;
  end
  assign o_read_buttons = fsm_q == REQUEST;
  assign o_state = btn_q;
  assign o_event_valid = cnt_q != 3'd0;
  assign o_event_button = o_event_valid ? mem_q[rd_q][3:1] : 3'd0;
  assign o_event_pressed = o_event_valid & mem_q[rd_q][0];
  assign o_overflow = ovf_q;
  assign o_timeout = tout_q;
endmodule

// File: tb/tb_nes_button_events.sv
// tb_nes_button_events: directed checks of polling, timeout, event diffing, FIFO overflow and reset
module tb_nes_button_events;
  logic clk = 1'b0;
  logic i_rst, o_read_buttons, i_valid, o_event_valid, i_event_ready, o_event_pressed, o_overflow, o_timeout;
  logic [7:0] i_buttons, o_state;
  logic [2:0] o_event_button;
  logic [3:0] q [$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  nes_button_events #(.CYCLES_PER_POLL(20), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .i_rst(i_rst), .o_read_buttons(o_read_buttons), .i_valid(i_valid),
    .i_buttons(i_buttons), .o_state(o_state), .o_event_valid(o_event_valid),
    .i_event_ready(i_event_ready), .o_event_button(o_event_button),
    .o_event_pressed(o_event_pressed), .o_overflow(o_overflow), .o_timeout(o_timeout)
  );
  always @(posedge clk) if (!i_rst && o_event_valid && i_event_ready) q.push_back({o_event_button, o_event_pressed});
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_read(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_read_buttons && n < 100);
    chk("read_seen", 32'(o_read_buttons), 1);
  endtask
  task automatic respond(input logic [7:0] v, input logic ready_after);
    int n;
    wait_read(n);
    @(negedge clk);
    i_valid = 1'b1;
    i_buttons = v;
    @(negedge clk);
    i_valid = 1'b0;
    if (ready_after) i_event_ready = 1'b1;
    repeat (14) @(negedge clk);
  endtask
  task automatic do_reset();
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    q.delete();
  endtask
  task automatic chk_events(input string tag, input logic [3:0] e [], input int len);
    chk({tag, "_count"}, 32'(q.size()), 32'(len));
    for (int i = 0; i < len && i < q.size(); i++) chk(tag, 32'(q[i]), 32'(e[i]));
  endtask
  initial begin
    int n, t_at, r_at;
    logic any_ev;
    logic [3:0] e2[] = '{4'hF, 4'h1};
    logic [3:0] e3[] = '{4'hE};
    logic [3:0] e4[] = '{4'hF, 4'hD, 4'hB, 4'h9};
    logic [3:0] e5[] = '{4'hF, 4'hD, 4'hB, 4'h9, 4'hE, 4'hC, 4'hA, 4'h8, 4'h7, 4'h5, 4'h3, 4'h1};
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_buttons = 8'h00;
    i_event_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(o_state), 0);
    chk("rst_valid", 32'(o_event_valid), 0);
    chk("rst_read", 32'(o_read_buttons), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    chk("rst_head", 32'({o_event_button, o_event_pressed}), 0);
    i_rst = 1'b0;
    wait_read(n);
    chk("first_read_delay", 32'(n), 21);
    t_at = 0;
    r_at = 0;
    any_ev = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_timeout && t_at == 0) t_at = k;
      if (o_read_buttons && r_at == 0) r_at = k;
      any_ev |= o_event_valid;
    end
    chk("timeout_offset", 32'(t_at), 9);
    chk("read_spacing", 32'(r_at), 20);
    chk("no_events", 32'(any_ev), 0);
    i_event_ready = 1'b1;
    q.delete();
    respond(8'h81, 1'b0);
    chk_events("ev_81", e2, 2);
    chk("state_81", 32'(o_state), 32'h81);
    q.delete();
    respond(8'h01, 1'b0);
    chk_events("ev_01", e3, 1);
    chk("state_01", 32'(o_state), 32'h01);
    do_reset();
    i_event_ready = 1'b0;
    respond(8'hFF, 1'b0);
    chk("ovf_ff", 32'(o_overflow), 1);
    chk("state_ff", 32'(o_state), 32'hFF);
    chk("head_ff", 32'({o_event_valid, o_event_button, o_event_pressed}), 32'h1F);
    i_event_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk_events("drain_ff", e4, 4);
    chk("ovf_sticky", 32'(o_overflow), 1);
    chk("drained", 32'(o_event_valid), 0);
    do_reset();
    i_event_ready = 1'b0;
    respond(8'hF0, 1'b0);
    chk("full_valid", 32'(o_event_valid), 1);
    chk("full_no_ovf", 32'(o_overflow), 0);
    respond(8'h0F, 1'b1);
    chk_events("ev_full_pop", e5, 12);
    chk("pop_no_ovf", 32'(o_overflow), 0);
    chk("state_0f", 32'(o_state), 32'h0F);
    i_event_ready = 1'b0;
    wait_read(n);
    @(negedge clk);
    i_valid = 1'b1;
    i_buttons = 8'hF0;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_diff_valid", 32'(o_event_valid), 1);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(o_event_valid), 0);
    chk("rst_mid_state", 32'(o_state), 0);
    chk("rst_mid_read", 32'(o_read_buttons), 0);
    @(negedge clk);
    i_rst = 1'b0;
    wait_read(n);
    chk("restart_delay", 32'(n), 21);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nes_button_events.md
NES_BUTTON_EVENTS -- requirements
Module: nes_button_events

Interface
REQ-001 SHALL have parameter CYCLES_PER_POLL, default 416667, clk cycles between poll requests (60 Hz at 25 MHz); legal range >= 16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, max clk cycles to wait for a controller response; legal range >= 2.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port o_read_buttons  output  1  one-cycle read strobe to the NES controller reader stage.
REQ-006 SHALL have port i_valid  input  1  one-cycle pulse from the reader; i_buttons is valid this cycle.
REQ-007 SHALL have port i_buttons  input  8  sampled buttons, 1 = pressed, bit 7 = A, bit 0 = Right.
REQ-008 SHALL have port o_state  output  8  last accepted button snapshot.
REQ-009 SHALL have port o_event_valid  output  1  event FIFO not empty.
REQ-010 SHALL have port i_event_ready  input  1  consumer pops the head event when high with o_event_valid.
REQ-011 SHALL have port o_event_button  output  3  head event button index (7 = A ... 0 = Right).
REQ-012 SHALL have port o_event_pressed  output  1  head event type, 1 = press, 0 = release.
REQ-013 SHALL have port o_overflow  output  1  sticky flag, event dropped on full FIFO.
REQ-014 SHALL have port o_timeout  output  1  one-cycle pulse when a read request gets no response.

Function
REQ-015 SHALL run a free-running poll counter 0..CYCLES_PER_POLL-1, wrapping; each wrap sets a single pending flag (further wraps while pending are lost, not queued).
REQ-016 SHALL implement FSM states IDLE, REQUEST, COLLECT, DIFF.
REQ-017 IDLE: when pending set -> clear pending, go REQUEST.
REQ-018 REQUEST: drive o_read_buttons high exactly this one cycle, clear timeout counter, go COLLECT.
REQ-019 COLLECT: on i_valid latch i_buttons, compute change mask = i_buttons XOR o_state, go DIFF; i_valid outside COLLECT SHALL be ignored.
REQ-020 COLLECT: after TIMEOUT_CYCLES cycles without i_valid, pulse o_timeout one cycle, go IDLE, o_state unchanged.
REQ-021 DIFF: scan mask bit 7 down to 0, one bit per cycle (8 cycles total); each set bit pushes {index, new value} into FIFO; then update o_state to latched snapshot and go IDLE.
REQ-022 SHALL store events in a 4-entry FIFO, first-in first-out; o_event_button/o_event_pressed show the head whenever o_event_valid is 1, and are 0 when empty.
REQ-023 Pop occurs when o_event_valid and i_event_ready; head advances next cycle.
REQ-024 Push when full SHALL drop the event and set o_overflow, unless a pop happens in the same cycle, in which case the push is accepted.
REQ-025 Simultaneous push and pop when empty SHALL not bypass; new event appears next cycle.
REQ-026 o_overflow SHALL stay set until reset; o_state SHALL update in DIFF even when events were dropped.
REQ-027 Minimum request spacing SHALL be CYCLES_PER_POLL cycles; no request while FSM is not IDLE.

Reset
REQ-028 i_rst high SHALL asynchronously force FSM IDLE, poll counter 0, pending 0, FIFO empty, o_state 0, all outputs 0, including mid-COLLECT or mid-DIFF.
REQ-029 After release, first o_read_buttons SHALL occur CYCLES_PER_POLL+1 cycles later (wrap, then REQUEST).

Verification (CYCLES_PER_POLL=20, TIMEOUT_CYCLES=8)
REQ-030 Reset release, no responses -> o_read_buttons pulse every 20 cycles; o_timeout pulse 8 cycles after each COLLECT entry; no events.
REQ-031 Response 8'h81 from zero state, ready=1 -> events (7,press) then (0,press); o_state=8'h81 after DIFF.
REQ-032 Next response 8'h01 -> single event (7,release); o_state=8'h01.
REQ-033 Ready=0, response 8'hFF from zero -> 4 events queued (7..4), o_overflow=1, o_state=8'hFF; then ready=1 drains 7,6,5,4 in order.
REQ-034 FIFO full, ready=1 during DIFF push -> no drop, o_overflow stays 0.
REQ-035 Assert i_rst mid-DIFF with events queued -> o_event_valid=0, o_state=0 immediately; restart per REQ-029.
